// File: rtl/sram_ctl_if.sv
// Host-side request/response bus of the SRAM controller.
// master = bus-side decoder, slave = sram_ctl.
interface sram_ctl_if #(
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 8
);
   logic                  req;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  ready;
   logic                  done;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  ready, done, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output ready, done, rdata
   );
endinterface

// File: rtl/sram_ctl.sv
// Clocked single-access controller for an asynchronous SRAM: setup/pulse/hold sequencing of CE, OE, WE and data.
// Latency accept->done is SETUP_CYC+PULSE_CYC+HOLD_CYC+1; requests are only taken while ready, never queued.
module sram_ctl #(
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 8,
   parameter int SETUP_CYC  = 1,
   parameter int PULSE_CYC  = 2,
   parameter int HOLD_CYC   = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   sram_ctl_if.slave             bus,
   output logic [ADDR_WIDTH-1:0] mem_address,
   inout  wire  [DATA_WIDTH-1:0] mem_data,
   output logic                  ceh_n,
   output logic                  ce2,
   output logic                  we_n,
   output logic                  oe_n
);

   localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int MAX_C  = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
   localparam int CNT_W  = $clog2(MAX_C + 1);

   localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   if (SETUP_CYC < 1) begin : g_bad_setup
      $error("sram_ctl: SETUP_CYC must be >= 1");
   end
   if (PULSE_CYC < 1) begin : g_bad_pulse
      $error("sram_ctl: PULSE_CYC must be >= 1");
   end
   if (HOLD_CYC < 1) begin : g_bad_hold
      $error("sram_ctl: HOLD_CYC must be >= 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_cnt_next;
   logic                  w_last;
   logic                  w_accept;
   logic                  w_is_write;

   logic                  r_we;
   logic [DATA_WIDTH-1:0] r_dq;
   logic                  r_dq_oe;
   logic                  r_done;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_ceh_n;
   logic                  r_we_n;
   logic                  r_oe_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Counter holds "cycles remaining minus one" and is reloaded on every state entry.
   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_accept   = 1'b0;
      w_last     = (r_cnt == '0);
      unique case (r_state)
         ST_IDLE: begin
            if (bus.req) begin
               w_accept   = 1'b1;
               w_next     = ST_SETUP;
               w_cnt_next = LD_SETUP;
            end
         end
         ST_SETUP: begin
            if (w_last) begin
               w_next     = ST_PULSE;
               w_cnt_next = LD_PULSE;
            end else begin
               w_cnt_next = r_cnt - CNT_ONE;
            end
         end
         ST_PULSE: begin
            if (w_last) begin
               w_next     = ST_HOLD;
               w_cnt_next = LD_HOLD;
            end else begin
               w_cnt_next = r_cnt - CNT_ONE;
            end
         end
         ST_HOLD: begin
            if (w_last) begin
               w_next     = ST_IDLE;
               w_cnt_next = '0;
            end else begin
               w_cnt_next = r_cnt - CNT_ONE;
            end
         end
         default: begin
            w_next     = ST_IDLE;
            w_cnt_next = '0;
         end
      endcase
      w_is_write = w_accept ? bus.we : r_we;
   end

   // Pins are registered from the next state so they change cleanly on the edge that enters each phase.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_we    <= 1'b0;
         r_dq    <= '0;
         r_dq_oe <= 1'b0;
         r_done  <= 1'b0;
         r_rdata <= '0;
         r_addr  <= '0;
         r_ceh_n <= 1'b1;
         r_we_n  <= 1'b1;
         r_oe_n  <= 1'b1;
      end else begin
         r_done <= (r_state == ST_HOLD) && w_last;
         if (w_accept) begin
            r_we   <= bus.we;
            r_dq   <= bus.wdata;
            r_addr <= bus.addr;
         end
         if ((r_state == ST_PULSE) && w_last && !r_we) begin
            r_rdata <= mem_data;
         end
         r_ceh_n <= (w_next == ST_IDLE);
         r_we_n  <= !(w_is_write && (w_next == ST_PULSE));
         r_oe_n  <= !(!w_is_write && ((w_next == ST_SETUP) || (w_next == ST_PULSE)));
         r_dq_oe <= w_is_write && (w_next != ST_IDLE);
      end
   end

   assign mem_data    = r_dq_oe ? r_dq : {DATA_WIDTH{1'bz}};
   assign mem_address = r_addr;
   assign ceh_n       = r_ceh_n;
   assign ce2         = 1'b1;
   assign we_n        = r_we_n;
   assign oe_n        = r_oe_n;

   assign bus.ready = (r_state == ST_IDLE);
   assign bus.done  = r_done;
   assign bus.rdata = r_rdata;

endmodule
